// File: rtl/wshb_fb_reader.sv
// ---------------------------------------------------------------------------
// wshb_fb_reader
//
// Wishbone master that streams a framebuffer out of SDRAM into the video path.
// It reads the frame sequentially in incrementing bursts of BURST_LEN 16-bit
// words starting at BASE_ADDR. Each word goes into a show-ahead FIFO, and the
// FIFO drives a valid/ready pixel stream. After the last pixel of a frame the
// read address returns to BASE_ADDR. pix_sof flags pixel 0 of every frame.
//
// A new burst is requested only when the FIFO already has room for a whole
// burst. Because of this reservation the FIFO can never overflow and no read
// is ever abandoned.
//
// Optional feature (macro WSHB_FB_READER_UNDERFLOW_EN):
//   When defined, underflow_cnt counts the cycles in which the consumer is
//   ready but no pixel is available. The count saturates and is cleared only
//   by reset. Counting starts once the first pixel 0 has been consumed after
//   enable rises. When undefined, underflow_cnt is tied to zero.
//
// Ports:
//   clk, rst_n     single clock; asynchronous active-low reset
//   enable         level-sensitive run request
//   wb_*           Wishbone B4 read master (classic transfers, cti tagged)
//   pix_data/valid/ready/sof   pixel stream taken from the FIFO head
//   underflow_cnt  stream underflow counter (zero unless the macro is set)
// ---------------------------------------------------------------------------
module wshb_fb_reader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [1:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned FRAME_PIX = HDISP * VDISP;
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned IW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] FRAME_LAST = IW'(FRAME_PIX - 1);
  // A burst may start only if the count is at or below this value.
  localparam logic [CW-1:0] ROOM_LIMIT = CW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Parameter legality
  // -------------------------------------------------------------------------
  if (BASE_ADDR[0] != 1'b0) begin : g_bad_base
    $fatal(1, "wshb_fb_reader: BASE_ADDR must be 2-byte aligned");
  end
  if (BURST_LEN == 0 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
    $fatal(1, "wshb_fb_reader: BURST_LEN must be a power of 2");
  end
  if ((FRAME_PIX % BURST_LEN) != 0) begin : g_bad_frame
    $fatal(1, "wshb_fb_reader: HDISP*VDISP must be a multiple of BURST_LEN");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 * BURST_LEN) begin : g_bad_fifo
    $fatal(1, "wshb_fb_reader: FIFO_DEPTH must be a power of 2 and >= 2*BURST_LEN");
  end

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [BW-1:0]   burst_cnt;
  logic [IW-1:0]   pix_idx;
  logic            stop_req;

  logic            ack_acc;
  logic            burst_last;
  logic            burst_stop;
  logic            flush;
  logic            room;

  logic [16:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            full;
  logic [16:0]     head;

  // -------------------------------------------------------------------------
  // Transfer bookkeeping
  // -------------------------------------------------------------------------
  // An ack arriving while the strobe is low does not belong to any of our
  // transfers, so it is ignored.
  assign ack_acc    = wb_stb && wb_ack;
  assign burst_last = (burst_cnt == BURST_LAST);
  // A stop requested at any point in the burst takes effect when the burst ends.
  assign burst_stop = stop_req || !enable;
  assign flush      = ack_acc && burst_last && burst_stop;
  assign room       = (count <= ROOM_LIMIT);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable && room) state_nxt = BURST;
      BURST:   if (ack_acc && burst_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_cti = 3'b000;
    if (state == BURST) begin
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_cti = burst_last ? 3'b111 : 3'b010;
    end
  end

  assign wb_we  = 1'b0;
  assign wb_sel = 2'b11;
  assign wb_bte = 2'b00;

  // -------------------------------------------------------------------------
  // Address, pixel index and burst position
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_adr    <= BASE_ADDR;
      pix_idx   <= '0;
      burst_cnt <= '0;
      stop_req  <= 1'b0;
    end else begin
      if (state == BURST && !enable) begin
        stop_req <= 1'b1;
      end
      if (ack_acc) begin
        if (burst_last) begin
          burst_cnt <= '0;
          stop_req  <= 1'b0;
        end else begin
          burst_cnt <= burst_cnt + 1'b1;
        end
        // A stopped run restarts at pixel 0. The frame wrap falls on a burst
        // end, so both reloads share one path.
        if (flush || pix_idx == FRAME_LAST) begin
          pix_idx <= '0;
          wb_adr  <= BASE_ADDR;
        end else begin
          pix_idx <= pix_idx + 1'b1;
          wb_adr  <= wb_adr + 32'd2;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Show-ahead pixel FIFO; bit 16 carries the start-of-frame tag
  // -------------------------------------------------------------------------
  assign push = ack_acc && !flush;
  assign pop  = pix_valid && pix_ready;
  assign full = (count == FULL_CNT);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {(pix_idx == '0), wb_dat_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign pix_valid = (count != '0);
  assign pix_data  = head[15:0];
  assign pix_sof   = pix_valid && head[16];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(full && wb_stb && wb_ack));

  // -------------------------------------------------------------------------
  // Underflow counter
  // -------------------------------------------------------------------------
`ifdef WSHB_FB_READER_UNDERFLOW_EN
  logic enable_q;
  logic uf_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q      <= 1'b0;
      uf_armed      <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      enable_q <= enable;
      // Disarm while stopped and on every enable rise. Then re-arm once
      // pixel 0 has actually been handed to the consumer.
      if (!enable || !enable_q) begin
        uf_armed <= 1'b0;
      end
      if (enable && pop && pix_sof) begin
        uf_armed <= 1'b1;
      end
      if (uf_armed && enable && pix_ready && !pix_valid && underflow_cnt != '1) begin
        underflow_cnt <= underflow_cnt + 1'b1;
      end
    end
  end
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_wshb_fb_reader.sv
module tb_wshb_fb_reader;

  localparam int unsigned FRAME = 32 * 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr;
  logic [1:0]  wb_sel, wb_bte;
  logic [2:0]  wb_cti;
  logic [15:0] wb_dat_i = 16'h0;
  logic        wb_ack = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid, pix_ready, pix_sof;
  logic [15:0] underflow_cnt;

  int checks = 0;
  int errors = 0;

  // slave model state
  int          slave_mode = 0;   // 0 silent, 1 ack every 2nd cycle, 2 ack always
  logic        phase = 1'b0;
  logic        cyc_prev = 1'b0;
  logic [31:0] exp_adr = 32'h0;
  int          bpos = 0;
  int          ack_total = 0;
  int          bursts = 0;
  // stream model state
  int          rd_idx = 0;

  wshb_fb_reader #(
    .BASE_ADDR (32'h0),
    .HDISP     (32),
    .VDISP     (16),
    .BURST_LEN (16),
    .FIFO_DEPTH(256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .wb_adr       (wb_adr),
    .wb_sel       (wb_sel),
    .wb_cti       (wb_cti),
    .wb_bte       (wb_bte),
    .wb_dat_i     (wb_dat_i),
    .wb_ack       (wb_ack),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_sof      (pix_sof),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [31:0] a);
    logic [15:0] w;
    w = a[16:1];
    return (w * 16'h9E37) ^ 16'h5A3C;
  endfunction

  // Wishbone slave: memory model plus checks on address and cti of every ack
  always @(negedge clk) begin
    wb_ack = 1'b0;
    if (wb_cyc && !cyc_prev) bursts++;
    cyc_prev = wb_cyc;
    if (slave_mode == 2) begin
      wb_ack = 1'b1;
    end else if (slave_mode == 1 && wb_stb) begin
      phase = ~phase;
      if (phase) begin
        wb_ack   = 1'b1;
        wb_dat_i = model(wb_adr);
        chk("ack_adr", wb_adr, exp_adr);
        chk("ack_cti", 32'(wb_cti), (bpos == 15) ? 32'd7 : 32'd2);
        exp_adr = (exp_adr + 32'd2) % (2 * FRAME);
        bpos = (bpos + 1) % 16;
        ack_total++;
      end
    end
  end

  // One cycle; any pop is checked against the stream model.
  task automatic tick(output bit popped);
    @(negedge clk);
    popped = 1'b0;
    if (pix_valid && pix_ready) begin
      chk("pix_data", 32'(pix_data), 32'(model(32'(2 * (rd_idx % FRAME)))));
      chk("pix_sof", 32'(pix_sof), 32'((rd_idx % FRAME) == 0));
      rd_idx++;
      popped = 1'b1;
    end
  endtask

  task automatic consume(input int n, input int budget);
    int got = 0;
    bit p;
    for (int c = 0; c < budget && got < n; c++) begin
      tick(p);
      if (p) got++;
    end
    chk("consume_count", 32'(got), 32'(n));
  endtask

  initial begin
    int a0;
    int cnt;
    bit p;
    bit stable;
    logic [31:0] sa;
    logic [2:0]  sc;
    logic [15:0] u0, u1;

    // ---- reset values
    rst_n = 1'b0; enable = 1'b0; pix_ready = 1'b0; slave_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_adr", wb_adr, 32'h0);
    chk("rst_cti", 32'(wb_cti), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_sof", 32'(pix_sof), 32'd0);
    chk("rst_uf", 32'(underflow_cnt), 32'd0);
    chk("const_we_sel_bte", {27'd0, wb_we, wb_sel, wb_bte}, 32'h0C);
    #1 rst_n = 1'b1;

    // ---- fill: exactly 16 bursts, then the master idles
    @(posedge clk); #1 enable = 1'b1;
    repeat (800) @(posedge clk);
    #1;
    chk("fill_bursts", 32'(bursts), 32'd16);
    chk("fill_acks", 32'(ack_total), 32'd256);
    chk("fill_cyc", 32'(wb_cyc), 32'd0);
    chk("fill_adr", wb_adr, 32'h200);
    chk("fill_valid", 32'(pix_valid), 32'd1);
    chk("fill_head_sof", 32'(pix_sof), 32'd1);
    chk("fill_head_data", 32'(pix_data), 32'(model(32'h0)));

    // ---- stray acks with no strobe are ignored
    slave_mode = 2;
    repeat (10) @(posedge clk);
    #1 slave_mode = 1;
    chk("stray_adr", wb_adr, 32'h200);
    chk("stray_cyc", 32'(wb_cyc), 32'd0);
    chk("stray_head", 32'(pix_data), 32'(model(32'h0)));

    // ---- stream across two frame wraps
    pix_ready = 1'b1;
    consume(1100, 5000);

    // ---- ack stall while strobing
    slave_mode = 0;
    cnt = 0;
    do begin tick(p); cnt++; end while (!wb_stb && cnt < 100);
    chk("stall_stb_seen", 32'(wb_stb), 32'd1);
    sa = wb_adr; sc = wb_cti; stable = 1'b1;
    u0 = '0; u1 = '0;
    for (int i = 0; i < 1000; i++) begin
      tick(p);
      if (wb_stb !== 1'b1 || wb_adr !== sa || wb_cti !== sc) stable = 1'b0;
      if (i == 100) begin
        chk("stall_drained", 32'(pix_valid), 32'd0);
        u0 = underflow_cnt;
      end
      if (i == 150) u1 = underflow_cnt;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    chk("stall_no_write", 32'(pix_valid), 32'd0);
`ifdef WSHB_FB_READER_UNDERFLOW_EN
    chk("uf_delta", 32'(u1 - u0), 32'd50);
`else
    chk("uf_delta", 32'(u1 - u0), 32'd0);
    chk("uf_zero", 32'(underflow_cnt), 32'd0);
`endif
    slave_mode = 1;
    consume(100, 600);

    // ---- enable dropped on the 5th ack of a burst
    pix_ready = 1'b0;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!(bpos == 5 && wb_stb) && cnt < 300);
    chk("drop_at_5th", 32'(bpos), 32'd5);
    chk("drop_fifo_busy", 32'(pix_valid), 32'd1);
    enable = 1'b0;
    a0 = ack_total;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (wb_cyc && cnt < 100);
    chk("drop_rest_acks", 32'(ack_total - a0), 32'd11);
    chk("drop_flushed", 32'(pix_valid), 32'd0);
    chk("drop_adr_base", wb_adr, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("drop_stays_idle", 32'(wb_cyc), 32'd0);
    exp_adr = 32'h0; bpos = 0; rd_idx = 0;
    enable = 1'b1; pix_ready = 1'b1;
    consume(40, 300);

    // ---- one-cycle reset pulse mid-burst
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!(wb_stb && bpos == 3) && cnt < 300);
    chk("rst_mid_burst", 32'(wb_stb), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(wb_cyc), 32'd0);
    chk("arst_stb", 32'(wb_stb), 32'd0);
    chk("arst_valid", 32'(pix_valid), 32'd0);
    chk("arst_adr", wb_adr, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    exp_adr = 32'h0; bpos = 0; rd_idx = 0; phase = 1'b0;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!wb_stb && cnt < 50);
    chk("post_rst_stb", 32'(wb_stb), 32'd1);
    chk("post_rst_adr", wb_adr, 32'h0);
    consume(40, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
